dmem_dump_uart: RTL and testbench

// - Downstream readout stage for the micro data path: when control_unit raises done, sweeps the data RAM over a fixed address window.
// - Sends each byte out of the board on a UART line as 8N1, LSB first. Lets the lab read results without ILA.
// - Drives the read side of dmem (addr/douta); the write side stays owned by control_unit.

---
 rtl/dmem_dump_uart_pkg.sv | 26 ++
 rtl/dmem_dump_uart_tx_byte.sv | 86 ++++++++
 rtl/dmem_dump_uart.sv | 94 +++++++++
 tb/tb_dmem_dump_uart.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_dump_uart_pkg.sv
// Shared types for the data-RAM UART dump path: sequencer states and
// the serializer's frame phases.
package dmem_dump_uart_pkg;

  localparam int FRAME_BITS       = 10;
  localparam int DEF_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_LATCH,
    ST_START_BIT,
    ST_DATA_BITS,
    ST_STOP_BIT,
    ST_NEXT,
    ST_FINISH
  } state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_START,
    PH_DATA,
    PH_STOP
  } tx_phase_e;

endpackage

// File: rtl/dmem_dump_uart_tx_byte.sv
// 8N1 byte serializer, LSB first. Owns the baud counter, bit index and
// shift register; the parent only sequences bytes.
module dmem_dump_uart_tx_byte
  import dmem_dump_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      start,
  input  logic [7:0] data,
  output logic      tx,
  output logic      ready,
  output tx_phase_e phase
);

  localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_phase_e        phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             tick;

  assign tick = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= PH_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  always_comb begin
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    if (phase_q != PH_IDLE) cnt_d = tick ? '0 : cnt_q + 1'b1;
    unique case (phase_q)
      PH_IDLE: if (start) begin
        shift_d   = data;
        tx_d      = 1'b0;
        cnt_d     = '0;
        bit_idx_d = '0;
        phase_d   = PH_START;
      end
      PH_START: if (tick) begin
        tx_d    = shift_q[0];
        phase_d = PH_DATA;
      end
      PH_DATA: if (tick) begin
        if (bit_idx_q == 3'd7) begin
          tx_d    = 1'b1;
          phase_d = PH_STOP;
        end else begin
          bit_idx_d = bit_idx_q + 3'd1;
          tx_d      = shift_q[bit_idx_q + 3'd1];
        end
      end
      PH_STOP: if (tick) begin
        tx_d    = 1'b1;
        phase_d = PH_IDLE;
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  // ready rises on the last stop-bit cycle so the parent's 3-cycle gap is exact
  assign ready = (phase_q == PH_IDLE) || ((phase_q == PH_STOP) && tick);
  assign tx    = tx_q;
  assign phase = phase_q;

endmodule

// File: rtl/dmem_dump_uart.sv
// Sweeps dmem over [START_ADDR, END_ADDR] on a rising edge of done and
// ships each byte out as an 8N1 UART frame. DATA_W must be 8.
module dmem_dump_uart
  import dmem_dump_uart_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int START_ADDR   = 0,
  parameter int END_ADDR     = 255,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              uart_tx,
  output logic              busy,
  output logic              dump_done
);

  localparam logic [ADDR_W-1:0] A_START = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] A_END   = ADDR_W'(END_ADDR);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q;
  logic              start_edge;
  logic              tx_start, tx_ready;
  tx_phase_e         tx_phase;

  assign start_edge = done && !done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= A_START;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      done_q  <= done;
    end
  end

  // Edges seen outside IDLE are dropped; FINISH waits only for done low.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      ST_IDLE: if (start_edge) begin
        addr_d  = A_START;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT:   state_d = ST_LATCH;
      ST_LATCH:     state_d = ST_START_BIT;
      ST_START_BIT: if (tx_phase == PH_DATA) state_d = ST_DATA_BITS;
      ST_DATA_BITS: if (tx_phase == PH_STOP) state_d = ST_STOP_BIT;
      ST_STOP_BIT:  if (tx_ready) state_d = ST_NEXT;
      ST_NEXT: begin
        // compare before incrementing so END_ADDR at the top never wraps
        if (addr_q == A_END) begin
          state_d = ST_FINISH;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_RD_WAIT;
        end
      end
      ST_FINISH: if (!done) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_start  = (state_q == ST_LATCH);
    busy      = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    dump_done = (state_q == ST_FINISH);
  end

  assign ram_addr = addr_q;

  dmem_dump_uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .start(tx_start),
    .data (ram_dout),
    .tx   (uart_tx),
    .ready(tx_ready),
    .phase(tx_phase)
  );

endmodule

// File: tb/tb_dmem_dump_uart.sv
// Three dump instances (full window, top-of-space window, single byte)
// against 1-cycle-latency RAM models and a mid-bit UART receiver.
module tb_dmem_dump_uart;

  logic       clk = 1'b0;
  logic       rst;
  logic       done [3];
  logic [7:0] addr [3];
  logic [7:0] dout [3];
  logic       tx   [3];
  logic       busy [3];
  logic       dd   [3];
  logic [7:0] mem  [256];
  int         cyc = 0;
  int         sel = 0;
  logic       txs;
  logic       saw_zero = 1'b0;
  int         nvec = 0;
  int         nmis = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_dump_uart #(.ADDR_W(8), .DATA_W(8), .START_ADDR(0), .END_ADDR(3), .CLKS_PER_BIT(4)) dut0 (
    .clk(clk), .rst(rst), .done(done[0]), .ram_addr(addr[0]), .ram_dout(dout[0]),
    .uart_tx(tx[0]), .busy(busy[0]), .dump_done(dd[0]));
  dmem_dump_uart #(.ADDR_W(8), .DATA_W(8), .START_ADDR(254), .END_ADDR(255), .CLKS_PER_BIT(4)) dut1 (
    .clk(clk), .rst(rst), .done(done[1]), .ram_addr(addr[1]), .ram_dout(dout[1]),
    .uart_tx(tx[1]), .busy(busy[1]), .dump_done(dd[1]));
  dmem_dump_uart #(.ADDR_W(8), .DATA_W(8), .START_ADDR(16), .END_ADDR(16), .CLKS_PER_BIT(4)) dut2 (
    .clk(clk), .rst(rst), .done(done[2]), .ram_addr(addr[2]), .ram_dout(dout[2]),
    .uart_tx(tx[2]), .busy(busy[2]), .dump_done(dd[2]));

  always @(posedge clk) begin
    dout[0] <= mem[addr[0]];
    dout[1] <= mem[addr[1]];
    dout[2] <= mem[addr[2]];
    if (!rst && addr[1] == 8'd0) saw_zero <= 1'b1;
  end

  assign txs = tx[sel];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tk(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Frame bits returned with fr[0]=start ... fr[9]=stop; fall=-1 on timeout.
  task automatic rx(input int lim, output logic [9:0] fr, output int fall);
    int w;
    fr   = '0;
    fall = -1;
    w    = 0;
    while (txs !== 1'b0 && w < lim) begin
      tk();
      w++;
    end
    if (txs === 1'b0) begin
      fall = cyc;
      tk(2);
      for (int b = 0; b < 10; b++) begin
        fr[b] = txs;
        if (b < 9) tk(4);
      end
    end
  endtask

  task automatic dump(input int idx, input int n, input int a0, input int first_fall);
    logic [9:0] fr;
    int f, pf;
    sel = idx;
    pf  = 0;
    for (int k = 0; k < n; k++) begin
      rx(200, fr, f);
      chk($sformatf("d%0d_seen%0d", idx, k), (f >= 0), 1);
      if (k == 0) begin
        if (first_fall >= 0) chk($sformatf("d%0d_latency", idx), f, first_fall);
      end else begin
        chk($sformatf("d%0d_spacing%0d", idx, k), f - pf, 43);
      end
      pf = f;
      chk($sformatf("d%0d_frame%0d", idx, k), fr, {1'b1, mem[a0 + k], 1'b0});
      chk($sformatf("d%0d_addr_hold%0d", idx, k), addr[idx], a0 + k);
    end
    tk(2);
    chk($sformatf("d%0d_dd_early", idx), dd[idx], 0);
    tk(1);
    chk($sformatf("d%0d_dd_set", idx), dd[idx], 1);
    chk($sformatf("d%0d_busy_clr", idx), busy[idx], 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] fr;
    int f, n;
    for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
    mem[0] = 8'hA5; mem[1] = 8'h00; mem[2] = 8'hFF; mem[3] = 8'h3C;
    mem[254] = 8'h5A; mem[255] = 8'hC3; mem[16] = 8'h81;
    rst = 1'b1;
    done[0] = 1'b0; done[1] = 1'b0; done[2] = 1'b0;
    tk(3);
    chk("rst_addr0", addr[0], 0);
    chk("rst_addr1", addr[1], 254);
    chk("rst_tx", tx[0], 1);
    chk("rst_busy", busy[0], 0);
    chk("rst_dd", dd[0], 0);
    rst = 1'b0;
    tk(2);

    // T1/T2: full window, start latency, busy timing, spacing
    done[0] = 1'b1;
    n = cyc + 1;
    chk("t2_busy_pre", busy[0], 0);
    tk(1);
    chk("t2_busy_n1", busy[0], 1);
    chk("t2_addr_start", addr[0], 0);
    tk(1);
    chk("t2_tx_n2", tx[0], 1);
    dump(0, 4, 0, n + 2);
    tk(5);
    chk("t1_dd_held", dd[0], 1);
    done[0] = 1'b0;
    tk(1);
    chk("t5_finish_idle", dd[0], 0);
    chk("t5_finish_busy", busy[0], 0);

    // T5: done toggling while busy produces a single dump
    done[0] = 1'b1;
    fork
      dump(0, 4, 0, -1);
      begin
        tk(12);
        done[0] = 1'b0; tk(1);
        done[0] = 1'b1; tk(1);
        done[0] = 1'b0; tk(1);
        done[0] = 1'b1;
      end
    join
    rx(100, fr, f);
    chk("t5_no_rerun", f, -1);
    chk("t5_dd_hold", dd[0], 1);
    done[0] = 1'b0;
    tk(1);
    chk("t5_idle", dd[0], 0);

    // T4: reset during data bit 4 of the first byte
    done[0] = 1'b1;
    tk(3);
    chk("t4_fall", tx[0], 0);
    tk(19);
    rst = 1'b1;
    done[0] = 1'b0;
    tk(1);
    chk("t4_tx", tx[0], 1);
    chk("t4_busy", busy[0], 0);
    chk("t4_dd", dd[0], 0);
    chk("t4_addr", addr[0], 0);
    tk(2);
    rst = 1'b0;
    tk(2);
    done[0] = 1'b1;
    n = cyc + 1;
    dump(0, 4, 0, n + 2);
    done[0] = 1'b0;
    tk(2);

    // T3: window at the top of the address space
    done[1] = 1'b1;
    n = cyc + 1;
    dump(1, 2, 254, n + 2);
    sel = 1;
    rx(60, fr, f);
    chk("t3_two_only", f, -1);
    chk("t3_no_wrap", saw_zero, 0);
    chk("t3_addr_end", addr[1], 255);
    done[1] = 1'b0;
    tk(2);

    // T6: single-byte window, explicit bit pattern 0,1,0,0,0,0,0,0,1,1
    done[2] = 1'b1;
    sel = 2;
    rx(20, fr, f);
    chk("t6_bits", fr, 10'h302);
    tk(2);
    chk("t6_dd_early", dd[2], 0);
    tk(1);
    chk("t6_dd", dd[2], 1);
    done[2] = 1'b0;
    tk(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
